// File: rtl/regsel_scoreboard.sv
// regsel_scoreboard: register index decoder with busy scoreboard and stall; define REGSEL_PC_BYPASS_EN to exempt PC_IDX from tracking
module regsel_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int PC_IDX = (1 << ADDR_W) - 1
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_addr,
  output logic                      alloc_ready,
  output logic                      en_valid,
  output logic [0:(1<<ADDR_W)-1]    en_onehot,
  input  logic                      rel_valid,
  input  logic [ADDR_W-1:0]         rel_addr,
  input  logic                      clear,
  output logic [0:(1<<ADDR_W)-1]    busy,
  output logic                      err_rel,
  output logic [7:0]                stall_cnt
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC = ADDR_W'(PC_IDX);
`ifdef REGSEL_PC_BYPASS_EN
  localparam bit PC_BYPASS = 1'b1;
`else
  localparam bit PC_BYPASS = 1'b0;
`endif
  logic [0:NREG-1] busy_nxt;
  logic [0:NREG-1] onehot_nxt;
  logic            accept;
  logic            rel_err;
  // a busy register is still allocatable when it is released in the same cycle
  assign alloc_ready = Resetn && !clear && (!busy[alloc_addr] || (rel_valid && rel_addr == alloc_addr));
  assign accept      = alloc_valid && alloc_ready;
  assign rel_err     = rel_valid && !busy[rel_addr] && !(PC_BYPASS && rel_addr == PC);
  // release first, then allocate, so a same-index pair leaves the register busy
  always_comb begin
    busy_nxt = busy;
    if (rel_valid) busy_nxt[rel_addr] = 1'b0;
    if (accept) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[PC] = busy_nxt[PC] && !PC_BYPASS;
    onehot_nxt = '0;
    onehot_nxt[alloc_addr] = accept;
  end
  // registered enable pulse, scoreboard, sticky error and saturating stall counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      en_valid  <= 1'b0;
      en_onehot <= '0;
      busy      <= '0;
      err_rel   <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      en_valid  <= accept;
      en_onehot <= onehot_nxt;
      busy      <= clear ? '0 : busy_nxt;
      err_rel   <= !clear && (err_rel || rel_err);
      stall_cnt <= clear ? 8'd0 :
                   (alloc_valid && !alloc_ready && stall_cnt != 8'hFF) ? stall_cnt + 8'd1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_regsel_scoreboard.sv
// tb_regsel_scoreboard: directed checks of decode, stall, release, clear, saturation, PC handling and wide reset
module tb_regsel_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic alloc_valid, rel_valid, clear, alloc_ready, en_valid, err_rel;
  logic [2:0] alloc_addr, rel_addr;
  logic [0:7] en_onehot, busy;
  logic [7:0] stall_cnt;
  logic b_rst_n, b_alloc_valid, b_rel_valid, b_clear, b_ready, b_en_valid, b_err;
  logic [3:0] b_alloc_addr, b_rel_addr;
  logic [0:15] b_en_onehot, b_busy;
  logic [7:0] b_stall;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regsel_scoreboard dut (
    .Clock(clk), .Resetn(rst_n), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready), .en_valid(en_valid), .en_onehot(en_onehot),
    .rel_valid(rel_valid), .rel_addr(rel_addr), .clear(clear), .busy(busy),
    .err_rel(err_rel), .stall_cnt(stall_cnt)
  );

  regsel_scoreboard #(.ADDR_W(4)) dut_w (
    .Clock(clk), .Resetn(b_rst_n), .alloc_valid(b_alloc_valid), .alloc_addr(b_alloc_addr),
    .alloc_ready(b_ready), .en_valid(b_en_valid), .en_onehot(b_en_onehot),
    .rel_valid(b_rel_valid), .rel_addr(b_rel_addr), .clear(b_clear), .busy(b_busy),
    .err_rel(b_err), .stall_cnt(b_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; b_rst_n = 1'b0;
    alloc_valid = 1'b1; alloc_addr = 3'd0; rel_valid = 1'b0; rel_addr = 3'd0; clear = 1'b0;
    b_alloc_valid = 1'b0; b_alloc_addr = 4'd0; b_rel_valid = 1'b0; b_rel_addr = 4'd0; b_clear = 1'b0;
    #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", alloc_ready); end
    total++; if ({en_valid, en_onehot, busy, err_rel, stall_cnt} !== 26'd0) begin bad++;
      $display("FAIL reset_outputs got=%b %b %b %b %h exp=all zero", en_valid, en_onehot, busy, err_rel, stall_cnt); end
    alloc_valid = 1'b0;
    #1;
    rst_n = 1'b1; b_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_alloc;
    alloc_valid = 1'b1; alloc_addr = 3'd3;
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL alloc_ready got=%b exp=1", alloc_ready); end
    tick;
    alloc_valid = 1'b0;
    total++; if (en_valid !== 1'b1) begin bad++; $display("FAIL alloc_en_valid got=%b exp=1", en_valid); end
    total++; if (en_onehot !== 8'b0001_0000) begin bad++; $display("FAIL alloc_onehot got=%b exp=00010000", en_onehot); end
    total++; if (busy !== 8'b0001_0000) begin bad++; $display("FAIL alloc_busy got=%b exp=00010000", busy); end
    tick;
    total++; if ({en_valid, en_onehot} !== 9'd0) begin bad++; $display("FAIL alloc_pulse_end got=%b %b exp=0 0", en_valid, en_onehot); end
  endtask

  task automatic test_stall_bypass;
    alloc_valid = 1'b1; alloc_addr = 3'd3;
    #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", alloc_ready); end
    repeat (4) tick;
    total++; if (stall_cnt !== 8'd4) begin bad++; $display("FAIL stall_cnt4 got=%0d exp=4", stall_cnt); end
    total++; if (en_valid !== 1'b0) begin bad++; $display("FAIL stall_no_pulse got=%b exp=0", en_valid); end
    rel_valid = 1'b1; rel_addr = 3'd3;
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b exp=1", alloc_ready); end
    tick;
    alloc_valid = 1'b0; rel_valid = 1'b0;
    total++; if (en_valid !== 1'b1 || en_onehot !== 8'b0001_0000) begin bad++;
      $display("FAIL bypass_pulse got=%b %b exp=1 00010000", en_valid, en_onehot); end
    total++; if (busy !== 8'b0001_0000 || err_rel !== 1'b0) begin bad++;
      $display("FAIL bypass_busy got=%b err=%b exp=00010000 err=0", busy, err_rel); end
    total++; if (stall_cnt !== 8'd4) begin bad++; $display("FAIL bypass_stall got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_err_clear;
    rel_valid = 1'b1; rel_addr = 3'd5;
    tick;
    rel_valid = 1'b0;
    total++; if (err_rel !== 1'b1 || busy !== 8'b0001_0000) begin bad++;
      $display("FAIL err_set got=%b busy=%b exp=1 busy=00010000", err_rel, busy); end
    repeat (2) tick;
    total++; if (err_rel !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_rel); end
    clear = 1'b1; alloc_valid = 1'b1; alloc_addr = 3'd2;
    #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b exp=0", alloc_ready); end
    tick;
    clear = 1'b0; alloc_valid = 1'b0;
    total++; if (en_valid !== 1'b0 || en_onehot !== 8'd0) begin bad++;
      $display("FAIL clear_pulse got=%b %b exp=0 0", en_valid, en_onehot); end
    total++; if (busy !== 8'd0 || err_rel !== 1'b0 || stall_cnt !== 8'd0) begin bad++;
      $display("FAIL clear_state got=%b %b %0d exp=0 0 0", busy, err_rel, stall_cnt); end
  endtask

  task automatic test_saturate;
    alloc_valid = 1'b1; alloc_addr = 3'd1;
    tick;
    repeat (300) tick;
    total++; if (stall_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", stall_cnt); end
    repeat (3) tick;
    total++; if (stall_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", stall_cnt); end
    alloc_valid = 1'b0; clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic test_pc;
    alloc_valid = 1'b1; alloc_addr = 3'd7;
    tick;
    total++; if (en_valid !== 1'b1 || en_onehot !== 8'b0000_0001) begin bad++;
      $display("FAIL pc_first got=%b %b exp=1 00000001", en_valid, en_onehot); end
    tick;
    alloc_valid = 1'b0;
`ifdef REGSEL_PC_BYPASS_EN
    total++; if (en_valid !== 1'b1 || busy !== 8'd0 || stall_cnt !== 8'd0) begin bad++;
      $display("FAIL pc_second got=%b busy=%b stall=%0d exp=1 busy=00000000 stall=0", en_valid, busy, stall_cnt); end
`else
    total++; if (en_valid !== 1'b0 || busy !== 8'b0000_0001 || stall_cnt !== 8'd1) begin bad++;
      $display("FAIL pc_second got=%b busy=%b stall=%0d exp=0 busy=00000001 stall=1", en_valid, busy, stall_cnt); end
`endif
    alloc_valid = 1'b1; alloc_addr = 3'd4; rel_valid = 1'b1; rel_addr = 3'd7;
    tick;
    alloc_valid = 1'b0; rel_valid = 1'b0;
    total++; if (busy !== 8'b0000_1000 || err_rel !== 1'b0 || en_onehot !== 8'b0000_1000) begin bad++;
      $display("FAIL dual_index got=%b err=%b oh=%b exp=00001000 err=0 oh=00001000", busy, err_rel, en_onehot); end
  endtask

  task automatic test_wide;
    b_alloc_valid = 1'b1; b_alloc_addr = 4'd15;
    tick;
    total++; if (b_en_valid !== 1'b1 || b_en_onehot !== 16'h0001) begin bad++;
      $display("FAIL wide_onehot got=%b %b exp=1 0000000000000001", b_en_valid, b_en_onehot); end
    for (int i = 0; i < 15; i++) begin
      b_alloc_addr = 4'(i);
      tick;
    end
`ifdef REGSEL_PC_BYPASS_EN
    total++; if (b_busy !== 16'hFFFE) begin bad++; $display("FAIL wide_busy got=%b exp=1111111111111110", b_busy); end
`else
    total++; if (b_busy !== 16'hFFFF) begin bad++; $display("FAIL wide_busy got=%b exp=1111111111111111", b_busy); end
`endif
    #2;
    b_rst_n = 1'b0;
    #1;
    total++; if ({b_en_valid, b_en_onehot, b_busy, b_err, b_stall, b_ready} !== 42'd0) begin bad++;
      $display("FAIL wide_async_reset got=%b %b %b %b %h %b exp=all zero", b_en_valid, b_en_onehot, b_busy, b_err, b_stall, b_ready); end
    b_alloc_valid = 1'b0;
    b_rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_alloc;
    test_stall_bypass;
    test_err_clear;
    test_saturate;
    test_pc;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
